// File: rtl/md_data_aligner.sv
// md_data_aligner: repacks variable MD RX transfers into fixed TX chunks.
// Define ALIGNER_IRQ_EN to build the IRQEN/IRQ registers and irq output.
module md_data_aligner #(
   parameter int ALGN_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [15:0]                paddr,
   input  logic                       pwrite,
   input  logic                       psel,
   input  logic                       penable,
   input  logic [31:0]                pwdata,
   output logic                       pready,
   output logic [31:0]                prdata,
   output logic                       pslverr,
   input  logic                       md_rx_valid,
   input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
   input  logic [1:0]                 md_rx_offset,
   input  logic [2:0]                 md_rx_size,
   output logic                       md_rx_ready,
   output logic                       md_rx_err,
   output logic                       md_tx_valid,
   output logic [ALGN_DATA_WIDTH-1:0] md_tx_data,
   output logic [1:0]                 md_tx_offset,
   output logic [2:0]                 md_tx_size,
   input  logic                       md_tx_ready,
   input  logic                       md_tx_err,
   output logic                       irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = ALGN_DATA_WIDTH;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   function automatic logic legal(
      input logic [1:0] off,
      input logic [2:0] sz
   );
      return (sz != 3'd0) &&
             (({2'b00, off} + {1'b0, sz}) <= 4'd4);
   endfunction

   function automatic logic [DW-1:0] bmask(
      input logic [2:0] nb
   );
      case (nb)
         3'd0:    return 32'h0000_0000;
         3'd1:    return 32'h0000_00FF;
         3'd2:    return 32'h0000_FFFF;
         3'd3:    return 32'h00FF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   logic [2:0]    ctrl_size;
   logic [1:0]    ctrl_off;
   logic [7:0]    cnt_drop;
   logic [7:0]    drop_nxt;

   logic          apb_acc;
   logic          apb_wr;
   logic          a_ctrl;
   logic          a_stat;
   logic          ctrl_ok;
   logic          ctrl_wr;
   logic          ctrl_clr;
   logic [31:0]   rdata;

   logic [DW-1:0] rx_dmem [FIFO_DEPTH];
   logic [1:0]    rx_omem [FIFO_DEPTH];
   logic [2:0]    rx_smem [FIFO_DEPTH];
   logic [PW-1:0] rx_wp;
   logic [PW-1:0] rx_rp;
   logic [CW-1:0] rx_cnt;
   logic [CW-1:0] rx_cnt_nxt;
   logic          rx_full;
   logic          rx_empty;
   logic          rx_take;
   logic          rx_push;
   logic          rx_pop;
   logic          rx_bad;

   logic [DW-1:0] tx_dmem [FIFO_DEPTH];
   logic [1:0]    tx_omem [FIFO_DEPTH];
   logic [2:0]    tx_smem [FIFO_DEPTH];
   logic [PW-1:0] tx_wp;
   logic [PW-1:0] tx_rp;
   logic [CW-1:0] tx_cnt;
   logic [CW-1:0] tx_cnt_nxt;
   logic          tx_full;
   logic          tx_empty;
   logic          tx_push;
   logic          tx_pop;
   logic [DW-1:0] tx_wdata;

   logic [DW-1:0] acc_data;
   logic [2:0]    acc_cnt;
   logic [2:0]    rx_used;
   logic [DW-1:0] head_data;
   logic [1:0]    head_off;
   logic [2:0]    head_size;
   logic [2:0]    left;
   logic [2:0]    room;
   logic [2:0]    n;
   logic [2:0]    start;
   logic [2:0]    new_cnt;
   logic [DW-1:0] take;
   logic [DW-1:0] new_acc;
   logic          core_en;
   logic          chunk;
   logic          unused_in;

`ifdef ALIGNER_IRQ_EN
   logic          a_irqen;
   logic          a_irq;
   logic [4:0]    irqen_q;
   logic [4:0]    irq_q;
   logic [4:0]    irq_ev;
   logic          irq_r;
`endif

   assign apb_acc  = psel & penable & ~reset_n;
   assign apb_wr   = apb_acc & pwrite;
   assign a_ctrl   = (paddr == 16'h0000);
   assign a_stat   = (paddr == 16'h000C);
   assign ctrl_ok  = legal(pwdata[9:8], pwdata[2:0]);
   assign ctrl_wr  = apb_wr & a_ctrl & ctrl_ok;
   assign ctrl_clr = apb_wr & a_ctrl & pwdata[16];

   assign pready  = apb_acc;
   assign pslverr = apb_wr & ((a_ctrl & ~ctrl_ok) | a_stat);
   assign prdata  = (apb_acc & ~pwrite) ? rdata : 32'h0;

   always_comb begin
      rdata = 32'h0;
      unique case (1'b1)
         a_ctrl: rdata = {22'h0, ctrl_off, 5'h0, ctrl_size};
         a_stat: rdata = {12'h0, 4'(tx_cnt), 4'h0,
                          4'(rx_cnt), cnt_drop};
`ifdef ALIGNER_IRQ_EN
         a_irqen: rdata = {27'h0, irqen_q};
         a_irq:   rdata = {27'h0, irq_q};
`endif
         default: rdata = 32'h0;
      endcase
   end

   assign rx_full     = (rx_cnt == FULL);
   assign rx_empty    = (rx_cnt == '0);
   assign md_rx_ready = ~reset_n & ~rx_full;
   assign rx_take     = md_rx_valid & md_rx_ready;
   assign rx_push     = rx_take & legal(md_rx_offset, md_rx_size);
   assign rx_bad      = rx_take & ~legal(md_rx_offset, md_rx_size);
   assign md_rx_err   = rx_bad;

   assign tx_full      = (tx_cnt == FULL);
   assign tx_empty     = (tx_cnt == '0);
   assign md_tx_valid  = ~reset_n & ~tx_empty;
   assign tx_pop       = md_tx_valid & md_tx_ready;
   assign md_tx_data   = md_tx_valid ? tx_dmem[tx_rp] : '0;
   assign md_tx_offset = md_tx_valid ? tx_omem[tx_rp] : 2'd0;
   assign md_tx_size   = md_tx_valid ? tx_smem[tx_rp] : 3'd0;

   // Core idles on a CTRL update so no bytes straddle two chunk formats.
   assign core_en = ~ctrl_wr;

   always_comb begin
      head_data = rx_dmem[rx_rp];
      head_off  = rx_omem[rx_rp];
      head_size = rx_smem[rx_rp];
      left      = head_size - rx_used;
      room      = ctrl_size - acc_cnt;
      n         = 3'd0;
      if (core_en && !rx_empty)
         n = (left < room) ? left : room;
      start    = {1'b0, head_off} + rx_used;
      take     = (head_data >> {start, 3'b000}) & bmask(n);
      new_acc  = acc_data | (take << {acc_cnt, 3'b000});
      new_cnt  = acc_cnt + n;
      chunk    = core_en && (new_cnt == ctrl_size);
      tx_push  = chunk && !tx_full;
      rx_pop   = (n != 3'd0) && ((rx_used + n) == head_size);
      tx_wdata = new_acc << {ctrl_off, 3'b000};
   end

   always_comb begin
      rx_cnt_nxt = rx_cnt;
      if (rx_push && !rx_pop)
         rx_cnt_nxt = rx_cnt + CW'(1);
      else if (!rx_push && rx_pop)
         rx_cnt_nxt = rx_cnt - CW'(1);
      tx_cnt_nxt = tx_cnt;
      if (tx_push && !tx_pop)
         tx_cnt_nxt = tx_cnt + CW'(1);
      else if (!tx_push && tx_pop)
         tx_cnt_nxt = tx_cnt - CW'(1);
      drop_nxt = cnt_drop;
      if (rx_bad && cnt_drop != 8'hFF)
         drop_nxt = cnt_drop + 8'd1;
      if (ctrl_clr)
         drop_nxt = 8'd0;
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         ctrl_size <= 3'd1;
         ctrl_off  <= 2'd0;
         cnt_drop  <= 8'd0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         rx_cnt    <= '0;
         tx_wp     <= '0;
         tx_rp     <= '0;
         tx_cnt    <= '0;
         acc_data  <= '0;
         acc_cnt   <= 3'd0;
         rx_used   <= 3'd0;
      end else begin
         if (ctrl_wr) begin
            ctrl_size <= pwdata[2:0];
            ctrl_off  <= pwdata[9:8];
         end
         cnt_drop <= drop_nxt;
         rx_cnt   <= rx_cnt_nxt;
         tx_cnt   <= tx_cnt_nxt;
         if (rx_push) rx_wp <= rx_wp + PW'(1);
         if (rx_pop)  rx_rp <= rx_rp + PW'(1);
         if (tx_push) tx_wp <= tx_wp + PW'(1);
         if (tx_pop)  tx_rp <= tx_rp + PW'(1);
         if (ctrl_wr || tx_push) begin
            acc_data <= '0;
            acc_cnt  <= 3'd0;
         end else begin
            acc_data <= new_acc;
            acc_cnt  <= new_cnt;
         end
         rx_used <= rx_pop ? 3'd0 : rx_used + n;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) begin
         rx_dmem[rx_wp] <= md_rx_data;
         rx_omem[rx_wp] <= md_rx_offset;
         rx_smem[rx_wp] <= md_rx_size;
      end
      if (tx_push) begin
         tx_dmem[tx_wp] <= tx_wdata;
         tx_omem[tx_wp] <= ctrl_off;
         tx_smem[tx_wp] <= ctrl_size;
      end
   end

`ifdef ALIGNER_IRQ_EN
   assign a_irqen = (paddr == 16'h00F0);
   assign a_irq   = (paddr == 16'h00F4);

   always_comb begin
      irq_ev[0] = !rx_empty && (rx_cnt_nxt == '0);
      irq_ev[1] = !rx_full && (rx_cnt_nxt == FULL);
      irq_ev[2] = !tx_empty && (tx_cnt_nxt == '0);
      irq_ev[3] = !tx_full && (tx_cnt_nxt == FULL);
      irq_ev[4] = (cnt_drop != 8'hFF) && (drop_nxt == 8'hFF);
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         irqen_q <= 5'h0;
         irq_q   <= 5'h0;
         irq_r   <= 1'b0;
      end else begin
         if (apb_wr && a_irqen)
            irqen_q <= pwdata[4:0];
         if (apb_wr && a_irq)
            irq_q <= (irq_q & ~pwdata[4:0]) | irq_ev;
         else
            irq_q <= irq_q | irq_ev;
         irq_r <= |(irq_q & irqen_q);
      end
   end

   assign irq = irq_r;
`else
   assign irq = 1'b0;
`endif

   assign unused_in = ^{md_tx_err, pwdata[31:17],
                        pwdata[15:10], pwdata[7:3]};

endmodule

// File: tb/tb_md_data_aligner.sv
// Directed bench for md_data_aligner: APB register table plus
// hand-written MD stream sequences with a TX capture queue.
module tb_md_data_aligner;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] paddr;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic        md_rx_valid;
   logic [31:0] md_rx_data;
   logic [1:0]  md_rx_offset;
   logic [2:0]  md_rx_size;
   logic        md_rx_ready;
   logic        md_rx_err;
   logic        md_tx_valid;
   logic [31:0] md_tx_data;
   logic [1:0]  md_tx_offset;
   logic [2:0]  md_tx_size;
   logic        md_tx_ready;
   logic        md_tx_err;
   logic        irq;

   int checks = 0;
   int failures = 0;
   logic [36:0] txq[$];

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } apb_vec_t;

   localparam int NV = 20;
   apb_vec_t vecs[NV];

   md_data_aligner dut (
      .clk(clk), .reset_n(reset_n),
      .paddr(paddr), .pwrite(pwrite), .psel(psel),
      .penable(penable), .pwdata(pwdata), .pready(pready),
      .prdata(prdata), .pslverr(pslverr),
      .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
      .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
      .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
      .md_tx_valid(md_tx_valid), .md_tx_data(md_tx_data),
      .md_tx_offset(md_tx_offset), .md_tx_size(md_tx_size),
      .md_tx_ready(md_tx_ready), .md_tx_err(md_tx_err),
      .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #2;
      if (md_tx_valid && md_tx_ready)
         txq.push_back({md_tx_data, md_tx_offset, md_tx_size});
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [15:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic err, output logic rdy);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1;
      rd = prdata; err = pslverr; rdy = pready;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [15:0] a,
                         input logic [31:0] exp);
      logic [31:0] rd;
      logic e, r;
      apb(1'b0, a, 32'h0, rd, e, r);
      chk(nm, rd, exp);
   endtask

   task automatic wr_chk(input string nm, input logic [15:0] a,
                         input logic [31:0] d, input logic exp_err);
      logic [31:0] rd;
      logic e, r;
      apb(1'b1, a, d, rd, e, r);
      chk(nm, e, exp_err);
   endtask

   task automatic md_send(input logic [31:0] d, input logic [1:0] o,
                          input logic [2:0] s, output logic err);
      logic got;
      got = 1'b0;
      err = 1'b0;
      @(negedge clk);
      md_rx_valid = 1'b1; md_rx_data = d;
      md_rx_offset = o; md_rx_size = s;
      for (int k = 0; k < 300 && !got; k++) begin
         #1;
         if (md_rx_ready) got = 1'b1;
         else @(negedge clk);
      end
      chk("rx_accept_wait", got, 1'b1);
      err = md_rx_err;
      @(negedge clk);
      md_rx_valid = 1'b0;
   endtask

   task automatic wait_txq(input int cnt, input string nm);
      for (int k = 0; k < 500 && txq.size() < cnt; k++)
         @(negedge clk);
      chk(nm, txq.size(), cnt);
   endtask

   function automatic logic [31:0] item(input int i);
      return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
   endfunction

   initial begin
      logic [31:0] rd;
      logic e, r;

      vecs[0]  = '{1'b0, 16'h0000, 32'h0,         32'h1,   1'b0};
      vecs[1]  = '{1'b1, 16'h0000, 32'h0000_0102, 32'h0,   1'b0};
      vecs[2]  = '{1'b0, 16'h0000, 32'h0,         32'h102, 1'b0};
      vecs[3]  = '{1'b1, 16'h0000, 32'h0000_0104, 32'h0,   1'b1};
      vecs[4]  = '{1'b0, 16'h0000, 32'h0,         32'h102, 1'b0};
      vecs[5]  = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0,   1'b1};
      vecs[6]  = '{1'b1, 16'h0000, 32'h0000_0301, 32'h0,   1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 32'h0,         32'h301, 1'b0};
      vecs[8]  = '{1'b1, 16'h000C, 32'hFFFF_FFFF, 32'h0,   1'b1};
      vecs[9]  = '{1'b0, 16'h000C, 32'h0,         32'h0,   1'b0};
      vecs[10] = '{1'b0, 16'h0010, 32'h0,         32'h0,   1'b0};
      vecs[11] = '{1'b1, 16'h0010, 32'h0000_1234, 32'h0,   1'b0};
      vecs[12] = '{1'b0, 16'h00F0, 32'h0,         32'h0,   1'b0};
      vecs[13] = '{1'b1, 16'h0000, 32'h00FF_0004, 32'h0,   1'b0};
      vecs[14] = '{1'b0, 16'h0000, 32'h0,         32'h4,   1'b0};
      vecs[15] = '{1'b1, 16'h0000, 32'h0000_0203, 32'h0,   1'b1};
      vecs[16] = '{1'b0, 16'h0000, 32'h0,         32'h4,   1'b0};
      vecs[17] = '{1'b1, 16'h0000, 32'h0000_0202, 32'h0,   1'b0};
      vecs[18] = '{1'b1, 16'h0000, 32'h0000_0004, 32'h0,   1'b0};
      vecs[19] = '{1'b0, 16'h0000, 32'h0,         32'h4,   1'b0};

      reset_n = 1'b1;
      paddr = 16'h0; pwrite = 1'b0; pwdata = 32'h0;
      psel = 1'b1; penable = 1'b1;
      md_rx_valid = 1'b1; md_rx_data = 32'h0;
      md_rx_offset = 2'd0; md_rx_size = 3'd0;
      md_tx_ready = 1'b0; md_tx_err = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_rx_ready", md_rx_ready, 1'b0);
      chk("rst_rx_err", md_rx_err, 1'b0);
      chk("rst_tx_valid", md_tx_valid, 1'b0);
      chk("rst_pready", pready, 1'b0);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_irq", irq, 1'b0);

      @(negedge clk);
      reset_n = 1'b0;
      psel = 1'b0; penable = 1'b0; md_rx_valid = 1'b0;
      md_tx_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_rx_ready", md_rx_ready, 1'b1);
      chk("idle_pready", pready, 1'b0);

      for (int i = 0; i < NV; i++) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, e, r);
         chk($sformatf("apb%0d_prdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("apb%0d_pslverr", i), e, vecs[i].exp_err);
         chk($sformatf("apb%0d_pready", i), r, 1'b1);
      end

      // Two half transfers merge into one SIZE=4 chunk.
      txq.delete();
      md_send(32'h4433_2211, 2'd0, 3'd2, e);
      chk("merge_a_err", e, 1'b0);
      md_send(32'h8877_6655, 2'd2, 3'd2, e);
      chk("merge_b_err", e, 1'b0);
      wait_txq(1, "merge_cnt");
      repeat (4) @(negedge clk);
      chk("merge_cnt_final", txq.size(), 1);
      chk("merge_entry", txq[0], {32'h8877_2211, 2'd0, 3'd4});

      // One word split into four single-byte chunks at lane 3.
      wr_chk("split_ctrl", 16'h0000, 32'h0000_0301, 1'b0);
      txq.delete();
      md_send(32'hDDCC_BBAA, 2'd0, 3'd4, e);
      wait_txq(4, "split_cnt");
      chk("split_0", txq[0], {32'hAA00_0000, 2'd3, 3'd1});
      chk("split_1", txq[1], {32'hBB00_0000, 2'd3, 3'd1});
      chk("split_2", txq[2], {32'hCC00_0000, 2'd3, 3'd1});
      chk("split_3", txq[3], {32'hDD00_0000, 2'd3, 3'd1});

      // Illegal transfers are dropped and counted.
      txq.delete();
      md_send(32'h1111_1111, 2'd3, 3'd2, e);
      chk("drop_err", e, 1'b1);
      rd_chk("drop_status", 16'h000C, 32'h0000_0001);
      chk("drop_no_tx", txq.size(), 0);
      wr_chk("clr_ctrl", 16'h0000, 32'h0001_0301, 1'b0);
      rd_chk("clr_status", 16'h000C, 32'h0);
      md_send(32'h0, 2'd0, 3'd0, e);
      chk("drop0_err", e, 1'b1);
      rd_chk("drop0_status", 16'h000C, 32'h0000_0001);
      wr_chk("clr_bad_ctrl", 16'h0000, 32'h0001_0000, 1'b1);
      rd_chk("clr_bad_status", 16'h000C, 32'h0);
      rd_chk("clr_bad_ctrl_rd", 16'h0000, 32'h0000_0301);

      // Backpressure: fill TX, accumulator and RX, then drain.
      wr_chk("bp_ctrl", 16'h0000, 32'h0000_0004, 1'b0);
      md_tx_ready = 1'b0;
      txq.delete();
      md_send(item(0), 2'd0, 3'd4, e);
      #1;
      chk("lat_not_yet", md_tx_valid, 1'b0);
      @(negedge clk);
      #1;
      chk("lat_valid", md_tx_valid, 1'b1);
      chk("lat_data", md_tx_data, item(0));
      for (int i = 1; i < 17; i++)
         md_send(item(i), 2'd0, 3'd4, e);
      repeat (4) @(negedge clk);
      rd_chk("bp_status", 16'h000C, 32'h0008_0800);
      #1;
      chk("bp_rx_ready", md_rx_ready, 1'b0);
      chk("bp_hold_data", md_tx_data, item(0));
      chk("bp_hold_size", md_tx_size, 3'd4);
      repeat (5) @(negedge clk);
      #1;
      chk("bp_stable_data", md_tx_data, item(0));
      chk("bp_stable_valid", md_tx_valid, 1'b1);
      @(negedge clk);
      md_tx_ready = 1'b1;
      for (int i = 17; i < 20; i++)
         md_send(item(i), 2'd0, 3'd4, e);
      wait_txq(20, "bp_cnt");
      for (int i = 0; i < 20 && i < txq.size(); i++)
         chk($sformatf("bp_item%0d", i), txq[i],
             {item(i), 2'd0, 3'd4});

`ifdef ALIGNER_IRQ_EN
      wr_chk("irq_clr_all", 16'h00F4, 32'h0000_001F, 1'b0);
      wr_chk("irqen_wr", 16'h00F0, 32'h0000_0004, 1'b0);
      rd_chk("irqen_rd", 16'h00F0, 32'h0000_0004);
      repeat (3) @(negedge clk);
      #1;
      chk("irq_idle", irq, 1'b0);
      md_send(32'h1234_5678, 2'd0, 3'd4, e);
      repeat (6) @(negedge clk);
      #1;
      chk("irq_tx_empty", irq, 1'b1);
      apb(1'b0, 16'h00F4, 32'h0, rd, e, r);
      chk("irq_bit2", rd[2], 1'b1);
      wr_chk("irq_w1c", 16'h00F4, 32'h0000_0004, 1'b0);
      repeat (3) @(negedge clk);
      #1;
      chk("irq_cleared", irq, 1'b0);
`endif

      // Reset with traffic in flight discards everything.
      md_tx_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         md_send(item(i), 2'd0, 3'd4, e);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("mid_rst_tx_valid", md_tx_valid, 1'b0);
      chk("mid_rst_rx_ready", md_rx_ready, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      rd_chk("post_rst_status", 16'h000C, 32'h0);
      rd_chk("post_rst_ctrl", 16'h0000, 32'h0000_0001);
      #1;
      chk("post_rst_tx_valid", md_tx_valid, 1'b0);
`ifndef ALIGNER_IRQ_EN
      chk("irq_tied_low", irq, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
